alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller for the 8-bit register/ALU datapath: three registers r1–r3, a tri-state source bus `input0`, adder and multiplier against `constant_load`, and a tri-state result bus `output0` written back to the registers.
- Accepts one micro-instruction per handshake (op, source register, destination register, immediate, carry-in).
- Sequences bus selects, the result-bus enable and the destination load pulse, so that there is never bus contention and the write-back happens exactly once.
- Replaces manual switch operation of the datapath.

Parameters:
- ADD_WAIT, 2: EXEC cycles allowed for adder settling (minimum 1).
- MUL_WAIT, 4: EXEC cycles allowed for multiplier settling (minimum 1).
- CNT_W, 3: width of the settle counter; must hold max(ADD_WAIT, MUL_WAIT).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- instr_valid  in  1  instruction offered.
- instr_op  in  2  00 ADD, 01 MUL, 10 MOV, 11 illegal.
- instr_src  in  2  01 r1, 10 r2, 11 r3, 00 illegal.
- instr_dst  in  2  same encoding as instr_src.
- instr_imm  in  8  immediate for ADD/MUL.
- instr_cin  in  1  carry-in for ADD.
- instr_ready  out  1  high in IDLE only.
- carry_out  in  1  adder carry from datapath.
- r1_select, r2_select, r3_select  out  1 each  source-bus drive enables.
- add_switch, mul_switch  out  1 each  result-bus drive enables.
- constant_load  out  8  ALU constant operand.
- carry_in  out  1  adder carry-in.
- r1_load, r2_load, r3_load  out  1 each  one-cycle register write pulses.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse on a rejected instruction.
- carry_flag  out  1  registered carry of the last ADD.

Behaviour:
- Reset (async, any state): state goes to IDLE. All selects, switches, loads, done and error are 0. constant_load=0, carry_in=0, carry_flag=0, instr_ready=1.
- Accept rule: the instruction is accepted on a clock edge with instr_valid && instr_ready. Fields are latched at acceptance; inputs are ignored while busy.
- Illegal instruction (op=11, src=00 or dst=00): go IDLE→ERR, pulse error for 1 cycle, then return to IDLE. No select, switch or load is asserted.
- MOV executes as ADD with constant_load=0 and carry_in=0. carry_flag is unchanged by MOV.
- ISSUE (1 cycle):
  - Exactly one rN_select asserted, per src.
  - constant_load and carry_in are driven from the latched instruction.
  - No result switch is on.
- EXEC (ADD_WAIT or MUL_WAIT cycles):
  - Source select is held.
  - add_switch (ADD/MOV) or mul_switch (MUL) is asserted, never both.
  - The counter loads WAIT−1 on entry and decrements; exit when it reaches 0.
- WRITE (1 cycle):
  - Select and switch are held.
  - Exactly one rN_load pulse, per dst.
  - ADD latches carry_out into carry_flag.
- DONE (1 cycle):
  - All selects, switches and loads are dropped.
  - done=1.
  - Next state IDLE.
- Latency from the accept edge to the done pulse: 1 + WAIT + 1 + 1 cycles (ADD default: 5; MUL default: 7). Throughput is one instruction per WAIT+4 cycles, because ready is low in DONE.
- src==dst is legal (e.g. r1←r1+imm). The load samples the result bus while the source is still driven.
- Invariants, checked every cycle:
  - At most one select is high.
  - At most one switch is high.
  - A load is high only in WRITE, with a switch high.
  - No switch is high without a select.
- Arithmetic: results are the datapath's 8-bit values. ADD wraps mod 256 with carry_out captured. MUL keeps the low 8 bits. The sequencer does no arithmetic of its own.
- Reset during EXEC or WRITE: outputs drop immediately and no load pulse is produced afterwards.

Decomposition:
- Shared package `alu_seq_pkg`:
  - opcode constants OP_ADD/OP_MUL/OP_MOV/OP_BAD;
  - register codes REG_NONE/REG_R1/REG_R2/REG_R3;
  - state enum IDLE, ISSUE, EXEC, WRITE, DONE, ERR.
- One sub-module, `reg_onehot_decode`: 2-bit register code plus enable in, 3-bit one-hot out. It is used for both the select outputs and the load outputs.

Test Plan:
- Reset, then ADD src=r1 dst=r2 imm=0x05 cin=0; bench models r1=0x10.
  - r1_select high for 4 cycles, add_switch for 3.
  - r2_load pulses exactly in cycle 4 after accept; done in cycle 5.
  - Model r2=0x15, carry_flag=0.
- ADD src=r3 dst=r3 imm=0xF0 cin=1 with r3=0x20 → r3=0x11, carry_flag=1.
- MUL src=r2 dst=r1 imm=0x03 with r2=0x15 → r1=0x3F. mul_switch high for 5 cycles, add_switch never high, done 7 cycles after accept.
- MOV src=r1 dst=r3 → constant_load=0 and carry_in=0 during the operation; r3 equals r1; carry_flag is unchanged.
- Illegal instructions (op=11, then src=00) → error pulse of 1 cycle each. No select, switch or load is ever high, and instr_ready returns after 1 cycle.
- Assert clear in EXEC of a MUL → all outputs 0 asynchronously, no rN_load pulse afterwards, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode/register codes, FSM states and decode helper for the ALU micro-sequencer.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    localparam logic [1:0] REG_NONE = 2'b00;
    localparam logic [1:0] REG_R1   = 2'b01;
    localparam logic [1:0] REG_R2   = 2'b10;
    localparam logic [1:0] REG_R3   = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    // An instruction is rejected when the opcode or either register code is unusable.
    function automatic logic is_illegal(input logic [1:0] op,
                                        input logic [1:0] src,
                                        input logic [1:0] dst);
        return (op == OP_BAD) || (src == REG_NONE) || (dst == REG_NONE);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Instruction handshake plus datapath control/feedback signals of the ALU sequencer.
interface alu_seq_if;
    logic       instr_valid;
    logic [1:0] instr_op;
    logic [1:0] instr_src;
    logic [1:0] instr_dst;
    logic [7:0] instr_imm;
    logic       instr_cin;
    logic       instr_ready;
    logic       carry_out;
    logic       r1_select;
    logic       r2_select;
    logic       r3_select;
    logic       add_switch;
    logic       mul_switch;
    logic [7:0] constant_load;
    logic       carry_in;
    logic       r1_load;
    logic       r2_load;
    logic       r3_load;
    logic       busy;
    logic       done;
    logic       error;
    logic       carry_flag;

    modport master (
        output instr_valid, instr_op, instr_src, instr_dst, instr_imm, instr_cin, carry_out,
        input  instr_ready, r1_select, r2_select, r3_select, add_switch, mul_switch,
               constant_load, carry_in, r1_load, r2_load, r3_load, busy, done, error, carry_flag
    );

    modport slave (
        input  instr_valid, instr_op, instr_src, instr_dst, instr_imm, instr_cin, carry_out,
        output instr_ready, r1_select, r2_select, r3_select, add_switch, mul_switch,
               constant_load, carry_in, r1_load, r2_load, r3_load, busy, done, error, carry_flag
    );
endinterface

// File: rtl/alu_seq_decode.sv
// Register code to one-hot strobe decoder, shared by the source selects and the write pulses.
module reg_onehot_decode
    import alu_seq_pkg::*;
(
    input  logic [1:0] i_code,
    input  logic       i_en,
    output logic [2:0] o_onehot
);

    // Gate the decode with the enable so no strobe can appear outside its window.
    always_comb begin
        o_onehot = 3'b000;
        if (i_en) begin
            case (i_code)
                REG_R1:  o_onehot = 3'b001;
                REG_R2:  o_onehot = 3'b010;
                REG_R3:  o_onehot = 3'b100;
                default: o_onehot = 3'b000;
            endcase
        end else begin
            o_onehot = 3'b000;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing bus selects, result switches and write-back pulses
// of the 8-bit register/ALU datapath, one micro-instruction per handshake.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ADD_WAIT = 2,
    parameter int MUL_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic      clock,
    input  logic      clear,
    alu_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] ADD_LOAD  = CNT_W'(ADD_WAIT - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_op;
    logic [1:0]       r_src;
    logic [1:0]       r_dst;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel_en;
    logic             r_ld_en;
    logic             r_add_sw;
    logic             r_mul_sw;
    logic [7:0]       r_const;
    logic             r_cin;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_carry_flag;

    logic [2:0]       w_sel;
    logic [2:0]       w_load;

    // Sequencer FSM: every control output is a flop updated together with the state.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state      <= IDLE;
            r_op         <= OP_ADD;
            r_src        <= REG_NONE;
            r_dst        <= REG_NONE;
            r_cnt        <= CNT_ZERO;
            r_sel_en     <= 1'b0;
            r_ld_en      <= 1'b0;
            r_add_sw     <= 1'b0;
            r_mul_sw     <= 1'b0;
            r_const      <= 8'h00;
            r_cin        <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_carry_flag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.instr_valid && r_ready) begin
                        r_op    <= bus.instr_op;
                        r_src   <= bus.instr_src;
                        r_dst   <= bus.instr_dst;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (is_illegal(bus.instr_op, bus.instr_src, bus.instr_dst)) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_state  <= ISSUE;
                            r_sel_en <= 1'b1;
                            // MOV rides the adder with a zero operand and no carry.
                            r_const  <= (bus.instr_op == OP_MOV) ? 8'h00 : bus.instr_imm;
                            r_cin    <= (bus.instr_op == OP_ADD) ? bus.instr_cin : 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    r_state  <= EXEC;
                    r_cnt    <= (r_op == OP_MUL) ? MUL_LOAD : ADD_LOAD;
                    r_mul_sw <= (r_op == OP_MUL);
                    r_add_sw <= (r_op != OP_MUL);
                end
                EXEC: begin
                    if (r_cnt == CNT_ZERO) begin
                        r_state <= WRITE;
                        r_ld_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                WRITE: begin
                    r_state  <= DONE;
                    r_ld_en  <= 1'b0;
                    r_sel_en <= 1'b0;
                    r_add_sw <= 1'b0;
                    r_mul_sw <= 1'b0;
                    r_const  <= 8'h00;
                    r_cin    <= 1'b0;
                    r_done   <= 1'b1;
                    if (r_op == OP_ADD) begin
                        r_carry_flag <= bus.carry_out;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                ERR: begin
                    r_state <= IDLE;
                    r_error <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_sel_en <= 1'b0;
                    r_ld_en  <= 1'b0;
                    r_add_sw <= 1'b0;
                    r_mul_sw <= 1'b0;
                    r_const  <= 8'h00;
                    r_cin    <= 1'b0;
                    r_done   <= 1'b0;
                    r_error  <= 1'b0;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    reg_onehot_decode u_sel_dec (
        .i_code   (r_src),
        .i_en     (r_sel_en),
        .o_onehot (w_sel)
    );

    reg_onehot_decode u_load_dec (
        .i_code   (r_dst),
        .i_en     (r_ld_en),
        .o_onehot (w_load)
    );

    assign bus.instr_ready   = r_ready;
    assign bus.r1_select     = w_sel[0];
    assign bus.r2_select     = w_sel[1];
    assign bus.r3_select     = w_sel[2];
    assign bus.add_switch    = r_add_sw;
    assign bus.mul_switch    = r_mul_sw;
    assign bus.constant_load = r_const;
    assign bus.carry_in      = r_cin;
    assign bus.r1_load       = w_load[0];
    assign bus.r2_load       = w_load[1];
    assign bus.r3_load       = w_load[2];
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
    assign bus.carry_flag    = r_carry_flag;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: emulates the register/ALU datapath, checks control timing per
// instruction and compares register contents against an instruction-level model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int ADD_WAIT = 2;
    localparam int MUL_WAIT = 4;
    localparam logic [21:0] IDLE_OUTS = 22'h200000;

    typedef struct {
        logic [1:0] op;
        logic [1:0] src;
        logic [1:0] dst;
        logic [7:0] imm;
        logic       cin;
        logic [7:0] exp_val;
        logic       exp_carry;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    logic dp_init;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0]  dp_reg [1:3];
    logic [7:0]  dp_bus;
    logic [7:0]  dp_result;
    logic [8:0]  dp_sum;
    logic [15:0] dp_prod;
    logic [7:0]  m_reg [1:3];
    logic        m_carry;

    always #5 clk = ~clk;

    alu_seq_if bus_if ();

    alu_sequencer #(.ADD_WAIT(ADD_WAIT), .MUL_WAIT(MUL_WAIT), .CNT_W(3)) dut (
        .clock (clk),
        .clear (clr),
        .bus   (bus_if)
    );

    // Datapath emulation: source bus, adder, multiplier and result bus.
    always_comb begin
        dp_bus = 8'h00;
        if (bus_if.r1_select)      dp_bus = dp_reg[1];
        else if (bus_if.r2_select) dp_bus = dp_reg[2];
        else if (bus_if.r3_select) dp_bus = dp_reg[3];
        else                       dp_bus = 8'h00;
        dp_sum    = {1'b0, dp_bus} + {1'b0, bus_if.constant_load} + {8'h00, bus_if.carry_in};
        dp_prod   = 16'(dp_bus) * 16'(bus_if.constant_load);
        dp_result = bus_if.add_switch ? dp_sum[7:0] : (bus_if.mul_switch ? dp_prod[7:0] : 8'h00);
    end

    assign bus_if.carry_out = dp_sum[8];

    always @(posedge clk) begin
        if (dp_init) begin
            dp_reg[1] <= 8'h10;
            dp_reg[2] <= 8'h00;
            dp_reg[3] <= 8'h20;
        end else begin
            if (bus_if.r1_load) dp_reg[1] <= dp_result;
            if (bus_if.r2_load) dp_reg[2] <= dp_result;
            if (bus_if.r3_load) dp_reg[3] <= dp_result;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] outs();
        return {bus_if.instr_ready, bus_if.busy, bus_if.done, bus_if.error, bus_if.carry_flag,
                bus_if.r1_select, bus_if.r2_select, bus_if.r3_select,
                bus_if.add_switch, bus_if.mul_switch,
                bus_if.r1_load, bus_if.r2_load, bus_if.r3_load,
                bus_if.carry_in, bus_if.constant_load};
    endfunction

    // Bus safety rules, sampled every cycle outside reset.
    always @(negedge clk) begin
        if (clr === 1'b0) begin
            check("invariants", 32'(
                ($countones({bus_if.r1_select, bus_if.r2_select, bus_if.r3_select}) <= 1) &&
                !(bus_if.add_switch && bus_if.mul_switch) &&
                ($countones({bus_if.r1_load, bus_if.r2_load, bus_if.r3_load}) <= 1) &&
                (!(bus_if.r1_load || bus_if.r2_load || bus_if.r3_load) ||
                 (bus_if.add_switch || bus_if.mul_switch)) &&
                (!(bus_if.add_switch || bus_if.mul_switch) ||
                 (bus_if.r1_select || bus_if.r2_select || bus_if.r3_select))), 32'd1);
        end
    end

    task automatic drive_garbage();
        bus_if.instr_op  = 2'($urandom);
        bus_if.instr_src = 2'($urandom);
        bus_if.instr_dst = 2'($urandom);
        bus_if.instr_imm = 8'($urandom);
        bus_if.instr_cin = 1'($urandom);
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                             input logic [7:0] imm, input logic cin, input string tag);
        int sel_n [1:3];
        int ld_n [1:3];
        int ld_at [1:3];
        int ex_sel [1:3];
        int ex_ldn [1:3];
        int ex_ldat [1:3];
        int add_n, mul_n, end_k, opnd_bad, wt, ex_end, ex_add, ex_mul;
        bit legal, got_err, got_done;
        logic [7:0]  ex_const;
        logic        ex_cin;
        logic [8:0]  s;
        logic [15:0] p;
        legal    = !((op == OP_BAD) || (src == REG_NONE) || (dst == REG_NONE));
        wt       = (op == OP_MUL) ? MUL_WAIT : ADD_WAIT;
        ex_const = (op == OP_MOV) ? 8'h00 : imm;
        ex_cin   = (op == OP_ADD) ? cin : 1'b0;
        add_n = 0; mul_n = 0; end_k = 0; opnd_bad = 0; got_err = 1'b0; got_done = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            sel_n[i] = 0; ld_n[i] = 0; ld_at[i] = 0;
            ex_sel[i]  = (legal && i == int'(src)) ? wt + 2 : 0;
            ex_ldn[i]  = (legal && i == int'(dst)) ? 1 : 0;
            ex_ldat[i] = (legal && i == int'(dst)) ? wt + 2 : 0;
        end
        ex_end = legal ? wt + 3 : 1;
        ex_add = (legal && op != OP_MUL) ? wt + 1 : 0;
        ex_mul = (legal && op == OP_MUL) ? wt + 1 : 0;

        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(bus_if.instr_ready), 32'd1);
        bus_if.instr_op = op; bus_if.instr_src = src; bus_if.instr_dst = dst;
        bus_if.instr_imm = imm; bus_if.instr_cin = cin; bus_if.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        drive_garbage();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus_if.r1_select) sel_n[1]++;
            if (bus_if.r2_select) sel_n[2]++;
            if (bus_if.r3_select) sel_n[3]++;
            if (bus_if.add_switch) add_n++;
            if (bus_if.mul_switch) mul_n++;
            if (bus_if.r1_load) begin ld_n[1]++; ld_at[1] = k; end
            if (bus_if.r2_load) begin ld_n[2]++; ld_at[2] = k; end
            if (bus_if.r3_load) begin ld_n[3]++; ld_at[3] = k; end
            if ((bus_if.r1_select || bus_if.r2_select || bus_if.r3_select) &&
                ((bus_if.constant_load != ex_const) || (op != OP_MUL && bus_if.carry_in != ex_cin)))
                opnd_bad++;
            if (bus_if.done || bus_if.error) begin
                got_done = bus_if.done;
                got_err  = bus_if.error;
                end_k    = k;
                check({tag, "_ready_low_at_end"}, 32'(bus_if.instr_ready), 32'd0);
                break;
            end
        end
        bus_if.instr_valid = 1'b0;

        check({tag, "_latency"}, 32'({got_err, got_done, 8'(end_k)}),
              32'({!legal, legal, 8'(ex_end)}));
        check({tag, "_sel_cycles"}, 32'({8'(sel_n[1]), 8'(sel_n[2]), 8'(sel_n[3])}),
              32'({8'(ex_sel[1]), 8'(ex_sel[2]), 8'(ex_sel[3])}));
        check({tag, "_switch_cycles"}, 32'({8'(add_n), 8'(mul_n)}),
              32'({8'(ex_add), 8'(ex_mul)}));
        check({tag, "_load_pulses"},
              32'({4'(ld_n[1]), 4'(ld_at[1]), 4'(ld_n[2]), 4'(ld_at[2]), 4'(ld_n[3]), 4'(ld_at[3])}),
              32'({4'(ex_ldn[1]), 4'(ex_ldat[1]), 4'(ex_ldn[2]), 4'(ex_ldat[2]),
                   4'(ex_ldn[3]), 4'(ex_ldat[3])}));
        check({tag, "_operands"}, 32'(opnd_bad), 32'd0);

        @(negedge clk);
        check({tag, "_ready_back"}, 32'({bus_if.instr_ready, bus_if.busy}), 32'(2'b10));

        if (legal) begin
            case (op)
                OP_ADD: begin
                    s = {1'b0, m_reg[src]} + {1'b0, imm} + {8'h00, cin};
                    m_reg[dst] = s[7:0];
                    m_carry    = s[8];
                end
                OP_MUL: begin
                    p = 16'(m_reg[src]) * 16'(imm);
                    m_reg[dst] = p[7:0];
                end
                default: m_reg[dst] = m_reg[src];
            endcase
        end
        check({tag, "_regs"}, 32'({dp_reg[1], dp_reg[2], dp_reg[3]}),
              32'({m_reg[1], m_reg[2], m_reg[3]}));
        check({tag, "_carry_flag"}, 32'(bus_if.carry_flag), 32'(m_carry));
    endtask

    vec_t vecs [7];
    int   bad_evt;

    initial begin
        vecs[0] = '{OP_ADD, REG_R1, REG_R2, 8'h05, 1'b0, 8'h15, 1'b0};
        vecs[1] = '{OP_ADD, REG_R3, REG_R3, 8'hF0, 1'b1, 8'h11, 1'b1};
        vecs[2] = '{OP_MUL, REG_R2, REG_R1, 8'h03, 1'b0, 8'h3F, 1'b1};
        vecs[3] = '{OP_MOV, REG_R1, REG_R3, 8'hAA, 1'b1, 8'h3F, 1'b1};
        vecs[4] = '{OP_BAD, REG_R1, REG_R2, 8'h12, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{OP_ADD, REG_NONE, REG_R1, 8'h34, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{OP_MUL, REG_R2, REG_NONE, 8'h56, 1'b0, 8'h00, 1'b1};

        clr = 1'b1; dp_init = 1'b1;
        bus_if.instr_valid = 1'b0; bus_if.instr_op = 2'b00; bus_if.instr_src = 2'b00;
        bus_if.instr_dst = 2'b00; bus_if.instr_imm = 8'h00; bus_if.instr_cin = 1'b0;
        m_reg[1] = 8'h10; m_reg[2] = 8'h00; m_reg[3] = 8'h20; m_carry = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(outs()), 32'(IDLE_OUTS));
        clr = 1'b0; dp_init = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'(outs()), 32'(IDLE_OUTS));

        for (int v = 0; v < 7; v++) begin
            run_instr(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].imm, vecs[v].cin,
                      $sformatf("vec%0d", v));
            if (!is_illegal(vecs[v].op, vecs[v].src, vecs[v].dst))
                check($sformatf("vec%0d_result", v), 32'(dp_reg[vecs[v].dst]), 32'(vecs[v].exp_val));
            check($sformatf("vec%0d_table_carry", v), 32'(bus_if.carry_flag), 32'(vecs[v].exp_carry));
        end

        for (int n = 0; n < 40; n++) begin
            logic [1:0] r_op_v, r_src_v, r_dst_v;
            r_op_v  = 2'($urandom_range(0, 3));
            r_src_v = ($urandom_range(0, 7) == 0) ? REG_NONE : 2'($urandom_range(1, 3));
            r_dst_v = ($urandom_range(0, 7) == 0) ? REG_NONE : 2'($urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_instr(r_op_v, r_src_v, r_dst_v, 8'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
        end

        // Clear in the middle of a MUL: everything drops at once and no write-back follows.
        @(negedge clk);
        bus_if.instr_op = OP_MUL; bus_if.instr_src = REG_R1; bus_if.instr_dst = REG_R2;
        bus_if.instr_imm = 8'h07; bus_if.instr_cin = 1'b0; bus_if.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_mid_exec_mul_on", 32'({bus_if.mul_switch, bus_if.r1_select}), 32'(2'b11));
        clr = 1'b1;
        #1;
        check("clr_async_outputs", 32'(outs()), 32'(IDLE_OUTS));
        m_carry = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        bad_evt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus_if.r1_load || bus_if.r2_load || bus_if.r3_load || bus_if.done || bus_if.busy)
                bad_evt++;
        end
        check("clr_no_late_activity", 32'(bad_evt), 32'd0);
        check("clr_ready", 32'(outs()), 32'(IDLE_OUTS));
        check("clr_regs", 32'({dp_reg[1], dp_reg[2], dp_reg[3]}), 32'({m_reg[1], m_reg[2], m_reg[3]}));
        run_instr(OP_ADD, REG_R2, REG_R1, 8'h81, 1'b1, "post_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
